// File: rtl/watch_pkg.sv
// watch_pkg: shared stopwatch types, digit limits and BCD helper
package watch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  typedef logic [3:0] bcd_t;
  localparam int BCD_MAX   = 9;
  localparam int SEC_T_MAX = 5;
  typedef struct packed {
    bcd_t       min_t;
    bcd_t       min_u;
    logic [2:0] sec_t;
    bcd_t       sec_u;
    bcd_t       ms_h;
    bcd_t       ms_t;
    bcd_t       ms_u;
  } digits_t;
  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: one wrapping decimal digit; clr has priority over inc
module bcd_digit_counter #(
  parameter int W    = 4,
  parameter int MAXV = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         carry_out
);
  assign carry_out = inc & (q == W'(MAXV));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= carry_out ? '0 : q + 1'b1;
endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD MM:SS.mmm stopwatch driven by a synchronised 1 kHz tick level.
// Optional lap snapshot display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_core
  import watch_pkg::*;
#(
  parameter int TICKS_PER_MS = 1,
  parameter int MAX_MIN      = 59
) (
  input  logic       CLOCK,
  input  logic       RST_n,
  input  logic       tick_lvl,
  input  logic       start_stop,
  input  logic       clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap,
  output logic       lap_hold,
`endif
  output logic       running,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [2:0] sec_t,
  output logic [3:0] sec_u,
  output logic [3:0] ms_h,
  output logic [3:0] ms_t,
  output logic [3:0] ms_u,
  output logic       wrap
);
  localparam logic [7:0] MAX_BCD  = to_bcd2(MAX_MIN);
  localparam logic [7:0] PRE_LAST = 8'(TICKS_PER_MS - 1);
  logic s1, s2, prev, ms_stb, run_stb, inc;
  logic [7:0] pre;
  state_t state_q, state_d;
  bcd_t min_t_q, min_u_q, sec_u_q, ms_h_q, ms_t_q, ms_u_q;
  logic [2:0] sec_t_q;
  logic c_msu, c_mst, c_msh, c_secu, c_sect, c_minu, c_mint, at_max, roll;
  digits_t live, shown;
  // two-flop synchroniser plus edge register; only rising edges count
  always_ff @(posedge CLOCK or negedge RST_n)
    if (!RST_n) {s1, s2, prev} <= '0;
    else {s1, s2, prev} <= {tick_lvl, s1, s2};
  assign ms_stb = s2 & ~prev;
  always_ff @(posedge CLOCK or negedge RST_n)
    if (!RST_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = clear ? IDLE : !start_stop ? state_q : (state_q == RUN ? PAUSE : RUN);
  assign running = state_q == RUN;
  assign run_stb = ms_stb & running;
  assign inc     = run_stb & (pre == PRE_LAST);
  always_ff @(posedge CLOCK or negedge RST_n)
    if (!RST_n) pre <= '0;
    else if (clear) pre <= '0;
    else if (run_stb) pre <= inc ? '0 : pre + 8'd1;
  bcd_digit_counter #(.W(4), .MAXV(BCD_MAX)) u_ms_u (
    .clk(CLOCK), .rst_n(RST_n), .clr(clear), .inc(inc), .q(ms_u_q), .carry_out(c_msu));
  bcd_digit_counter #(.W(4), .MAXV(BCD_MAX)) u_ms_t (
    .clk(CLOCK), .rst_n(RST_n), .clr(clear), .inc(c_msu), .q(ms_t_q), .carry_out(c_mst));
  bcd_digit_counter #(.W(4), .MAXV(BCD_MAX)) u_ms_h (
    .clk(CLOCK), .rst_n(RST_n), .clr(clear), .inc(c_mst), .q(ms_h_q), .carry_out(c_msh));
  bcd_digit_counter #(.W(4), .MAXV(BCD_MAX)) u_sec_u (
    .clk(CLOCK), .rst_n(RST_n), .clr(clear), .inc(c_msh), .q(sec_u_q), .carry_out(c_secu));
  bcd_digit_counter #(.W(3), .MAXV(SEC_T_MAX)) u_sec_t (
    .clk(CLOCK), .rst_n(RST_n), .clr(clear), .inc(c_secu), .q(sec_t_q), .carry_out(c_sect));
  // the minute pair wraps as a whole when it equals MAX_MIN in BCD
  assign at_max = {min_t_q, min_u_q} == MAX_BCD;
  assign roll   = c_sect & at_max;
  bcd_digit_counter #(.W(4), .MAXV(BCD_MAX)) u_min_u (
    .clk(CLOCK), .rst_n(RST_n), .clr(clear | roll), .inc(c_sect & ~at_max), .q(min_u_q),
    .carry_out(c_minu));
  bcd_digit_counter #(.W(4), .MAXV(BCD_MAX)) u_min_t (
    .clk(CLOCK), .rst_n(RST_n), .clr(clear | roll), .inc(c_minu), .q(min_t_q),
    .carry_out(c_mint));
  always_ff @(posedge CLOCK or negedge RST_n)
    if (!RST_n) wrap <= 1'b0;
    else wrap <= ~clear & (roll | c_mint);
  assign live = {min_t_q, min_u_q, sec_t_q, sec_u_q, ms_h_q, ms_t_q, ms_u_q};
`ifdef STOPWATCH_LAP_EN
  digits_t snap;
  // lap freezes the display on a snapshot while the live count keeps running
  always_ff @(posedge CLOCK or negedge RST_n)
    if (!RST_n) begin
      lap_hold <= 1'b0;
      snap     <= '0;
    end else if (clear) lap_hold <= 1'b0;
    else if (lap && running) begin
      lap_hold <= ~lap_hold;
      if (!lap_hold) snap <= live;
    end
  assign shown = lap_hold ? snap : live;
`else
  assign shown = live;
`endif
  assign {min_t, min_u, sec_t, sec_u, ms_h, ms_t, ms_u} = shown;
endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Downstream consumer of the watch's 1 kHz divided-clock output; runs entirely on the 50 MHz system clock.
- Synchronises the divided-clock level, edge-detects it into a one-cycle ms strobe, and counts elapsed time in BCD (MM:SS.mmm).
- Start/stop/clear control comes from debounced single-cycle key pulses. Digit outputs feed the 7-segment scan stage.

Parameters:
- TICKS_PER_MS, 1, rising edges of tick_lvl per millisecond increment (1..255)
- MAX_MIN, 59, highest minute value before wrap (1..99)

Ports:
- CLOCK  in  1  system clock, 50 MHz; all state updates on posedge
- RST_n  in  1  asynchronous active-low reset
- tick_lvl  in  1  divided-clock level from the divider; any phase relation to CLOCK
- start_stop  in  1  one-cycle pulse; toggles run/pause
- clear  in  1  one-cycle pulse; zeroes the count, returns to IDLE
- running  out  1  high in RUN
- min_t  out  4  minutes tens, BCD
- min_u  out  4  minutes units, BCD
- sec_t  out  3  seconds tens, 0..5
- sec_u  out  4  seconds units, BCD
- ms_h  out  4  ms hundreds, BCD
- ms_t  out  4  ms tens, BCD
- ms_u  out  4  ms units, BCD
- wrap  out  1  one-cycle pulse when the count rolls MAX_MIN:59.999 -> 00:00.000

Behaviour:
- Reset (async assert, sync release): all digits 0, running=0, wrap=0, state IDLE, synchroniser and edge regs 0, prescaler 0.
- Tick path:
  - tick_lvl passes through 2 flops, then an edge register.
  - ms_stb = sync & ~prev. First strobe comes 3 CLOCK edges after a tick_lvl rise.
  - Falling edges are ignored.
- Prescaler counts ms_stb modulo TICKS_PER_MS. It advances only in RUN and is zeroed on clear.
- inc pulse = ms_stb in RUN with prescaler at TICKS_PER_MS-1. The digit chain updates on that same edge, so digits change 1 cycle after ms_stb is high.
- Carry chain: ms_u -> ms_t -> ms_h -> sec_u -> sec_t -> min_u -> min_t.
  - Units and ms digits wrap 9->0; sec_t wraps 5->0.
  - Minutes wrap at MAX_MIN. Minute pair compares as BCD value == MAX_MIN.
  - At full wrap, all digits go to 0 and wrap pulses high for exactly one cycle.
- State machine (state registered; decisions use the current state):
  - IDLE: start_stop -> RUN.
  - RUN: start_stop -> PAUSE.
  - PAUSE: start_stop -> RUN; digits hold.
  - clear in any state -> IDLE; digits and prescaler zeroed on the next edge.
- Simultaneous events:
  - clear and start_stop together: clear wins, state IDLE.
  - clear and inc together: clear wins, digits 0.
  - start_stop and inc in RUN: the increment is applied and state moves to PAUSE.
  - start_stop and ms_stb in IDLE/PAUSE: no increment; counting starts from the next strobe.
- Prescaler remainder is kept across PAUSE/RUN, so resuming does not restart the partial ms.
- Digits never hold non-BCD values; a reachable illegal value counts as a design bug.
- Reset mid-count immediately forces all outputs to reset values.

Optional Feature:
- Macro STOPWATCH_LAP_EN.
- With macro:
  - Extra input lap (1-cycle pulse) and output lap_hold (1).
  - In RUN, lap toggles lap_hold.
  - While lap_hold=1, the digit outputs show a snapshot taken on the lap edge, and the internal count keeps running.
  - Leaving RUN via start_stop keeps lap_hold; clear forces lap_hold=0.
  - lap in IDLE/PAUSE is ignored.
  - Snapshot and lap_hold reset to 0.
- Without macro: no lap port or logic; digit outputs are always live.

Decomposition:
- Shared package watch_pkg:
  - state enum {IDLE, RUN, PAUSE}
  - bcd_t (4-bit) typedef
  - constants BCD_MAX=9, SEC_T_MAX=5
- One sub-module bcd_digit_counter:
  - Parameter MAXV.
  - Ports: clk, rst_n, clr, inc, q, carry_out.
  - carry_out = inc & (q==MAXV).
  - Instantiated per digit; minute pair handled in the top level for MAX_MIN wrap.

Test Plan:
- Reset with tick_lvl toggling -> all digits 0, running=0, no wrap; after RST_n release, no count until start_stop.
- start_stop, then 1234 tick_lvl rises -> 00:01.234, running=1. start_stop, then 50 more rises -> still 00:01.234, running=0.
- TICKS_PER_MS=4, RUN, 10 rises -> ms_u=2. Pause after the 2nd of the next 3 rises, resume, 2 more rises -> ms_u=3 (prescaler remainder kept).
- Preload to MAX_MIN:59.998 via ticks (MAX_MIN=1), 2 rises -> 01:59.999, then 00:00.000 with wrap high exactly 1 cycle.
- clear and start_stop in the same cycle while running at 00:05.000 -> IDLE, all 0. clear coincident with inc -> digits 0, not 0.001.
- STOPWATCH_LAP_EN: run to 00:02.000, lap, 500 rises -> outputs 00:02.000. lap again -> outputs 00:02.500. clear -> lap_hold=0, all 0.
